reg_dump_loader: RTL and testbench
==================================

REG_DUMP_LOADER -- requirements
Module: reg_dump_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter FIRST_REG, default 1, SHALL set the first register index accessed.
REQ-003 Parameter LAST_REG, default 31, SHALL set the last register index accessed; FIRST_REG >= 1 and FIRST_REG <= LAST_REG.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 start_dump  in  1  one-cycle request to read registers out.
REQ-007 start_load  in  1  one-cycle request to write registers in.
REQ-008 busy  out  1  high while a dump or load is in progress.
REQ-009 done  out  1  one-cycle pulse at completion.
REQ-010 RA1, RA2  out  5 each  register-file read addresses.
REQ-011 RD1, RD2  in  32 each  register-file read data, combinational from RA1/RA2.
REQ-012 WE3  out  1, WA3  out  5, WD3  out  32  register-file write port, written on rising clk.
REQ-013 dout_valid out 1, dout_ready in 1, dout_data out 32, dout_idx out 5  dump stream.
REQ-014 din_valid in 1, din_ready out 1, din_data in 32  load stream.

Function
REQ-015 States SHALL be IDLE, DUMP_READ, DUMP_OUT0, DUMP_OUT1, LOAD, DONE; the index counter idx SHALL be 5 bits.
REQ-016 IDLE: on start_dump, idx<=FIRST_REG and go to DUMP_READ; else on start_load, idx<=FIRST_REG and go to LOAD; dump wins when both are high.
REQ-017 start_dump and start_load SHALL be ignored outside IDLE.
REQ-018 busy SHALL be high in every state except IDLE and DONE.
REQ-019 DUMP_READ (1 cycle): RA1=idx and RA2=min(idx+1, LAST_REG); the clock edge captures RD1->buf0 and RD2->buf1, then go to DUMP_OUT0.
REQ-020 DUMP_OUT0: dout_valid=1, dout_data=buf0, dout_idx=idx; on handshake go to DONE if idx==LAST_REG, else go to DUMP_OUT1.
REQ-021 DUMP_OUT1: dout_valid=1, dout_data=buf1, dout_idx=idx+1; on handshake go to DONE if idx+1==LAST_REG, else idx<=idx+2 and go to DUMP_READ.
REQ-022 While dout_valid=1 and dout_ready=0, dout_data and dout_idx SHALL hold stable; dout_valid SHALL not drop without a handshake.
REQ-023 LOAD: din_ready=1, WE3=din_valid, WA3=idx, WD3=din_data (combinational); on handshake go to DONE if idx==LAST_REG, else idx<=idx+1.
REQ-024 WE3 SHALL be 0 in every state except LOAD, and SHALL never assert with WA3=0.
REQ-025 din_ready SHALL be 0 outside LOAD; dout_valid SHALL be 0 outside DUMP_OUT0 and DUMP_OUT1.
REQ-026 DONE: done=1 for exactly one cycle, then go to IDLE; no new start is accepted in DONE.
REQ-027 Dump latency: the first dout_valid SHALL occur 2 cycles after the start_dump edge; with ready held high, throughput SHALL be 2 words per 3 cycles.

Reset
REQ-028 reset SHALL immediately force state IDLE, idx=0, buf0=buf1=0, and all outputs to 0, independent of clk.
REQ-029 Reset mid-operation SHALL abort without issuing a further WE3; the next start SHALL restart at FIRST_REG.

Structure
REQ-030 A shared package/header SHALL hold the state encodings, REG_ADDR_W=5, DATA_W=32 and NUM_REGS=32.
REQ-031 The block SHALL be a single module with no sub-module; the register file stays external and is connected at top level.

Verification
REQ-032 Load x1..x31 with 0x100+i (ready/valid always high), then dump: 31 beats, idx 1..31, data 0x100+i, one done pulse.
REQ-033 Dump with dout_ready low for 3 cycles at idx 5: valid held, data 0x105 stable, no index skipped or repeated.
REQ-034 Load with din_valid gaps: WE3 pulses only on handshake cycles, and WA3 advances by exactly 1 per handshake.
REQ-035 start_dump and start_load in the same cycle: dump runs, din_ready and WE3 stay 0 throughout.
REQ-036 reset asserted mid-dump at idx 12: busy, dout_valid and WE3 fall without a clock edge; the next start_dump emits idx 1 first.
REQ-037 FIRST_REG=LAST_REG=9 with x9=0x204: single beat idx 9, data 0x204, done pulse, no DUMP_OUT1 beat.

Source files
------------

// File: rtl/reg_dump_loader_pkg.sv
// Shared widths and FSM encoding for the register dump/load engine.
package reg_dump_loader_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [2:0] {
    StIdle,
    StDumpRead,
    StDumpOut0,
    StDumpOut1,
    StLoad,
    StDone
  } state_e;

endpackage

// File: rtl/reg_dump_loader_if.sv
// Control, register-file and stream signals between the loader and its surroundings.
interface reg_dump_loader_if;
  import reg_dump_loader_pkg::*;

  logic                  start_dump;
  logic                  start_load;
  logic                  busy;
  logic                  done;
  logic [REG_ADDR_W-1:0] RA1;
  logic [REG_ADDR_W-1:0] RA2;
  logic [DATA_W-1:0]     RD1;
  logic [DATA_W-1:0]     RD2;
  logic                  WE3;
  logic [REG_ADDR_W-1:0] WA3;
  logic [DATA_W-1:0]     WD3;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [DATA_W-1:0]     dout_data;
  logic [REG_ADDR_W-1:0] dout_idx;
  logic                  din_valid;
  logic                  din_ready;
  logic [DATA_W-1:0]     din_data;

  modport master (
    input  start_dump, start_load, RD1, RD2, dout_ready, din_valid, din_data,
    output busy, done, RA1, RA2, WE3, WA3, WD3, dout_valid, dout_data, dout_idx, din_ready
  );

  modport slave (
    output start_dump, start_load, RD1, RD2, dout_ready, din_valid, din_data,
    input  busy, done, RA1, RA2, WE3, WA3, WD3, dout_valid, dout_data, dout_idx, din_ready
  );

endinterface

// File: rtl/reg_dump_loader.sv
// Streams registers FIRST_REG..LAST_REG out of an external register file (two per read)
// or writes them in from a load stream.
module reg_dump_loader
  import reg_dump_loader_pkg::*;
#(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31
) (
  input logic              clk,
  input logic              reset,
  reg_dump_loader_if.master bus
);

  localparam logic [REG_ADDR_W-1:0] First = REG_ADDR_W'(FIRST_REG);
  localparam logic [REG_ADDR_W-1:0] Last  = REG_ADDR_W'(LAST_REG);

  state_e                state_q;
  logic [REG_ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0]     buf0_q;
  logic [DATA_W-1:0]     buf1_q;

  logic [REG_ADDR_W:0]   idx_p1_wide;
  logic [REG_ADDR_W-1:0] idx_p1;
  logic                  dout_hs;
  logic                  din_hs;

  assign idx_p1_wide = {1'b0, idx_q} + 6'd1;
  assign idx_p1      = idx_q + 5'd1;
  assign dout_hs     = ((state_q == StDumpOut0) || (state_q == StDumpOut1)) && bus.dout_ready;
  assign din_hs      = (state_q == StLoad) && bus.din_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start_dump) begin
            idx_q   <= First;
            state_q <= StDumpRead;
          end else if (bus.start_load) begin
            idx_q   <= First;
            state_q <= StLoad;
          end
        end
        StDumpRead: begin
          buf0_q  <= bus.RD1;
          buf1_q  <= bus.RD2;
          state_q <= StDumpOut0;
        end
        StDumpOut0: begin
          if (dout_hs) state_q <= (idx_q == Last) ? StDone : StDumpOut1;
        end
        StDumpOut1: begin
          if (dout_hs) begin
            if (idx_p1 == Last) begin
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 5'd2;
              state_q <= StDumpRead;
            end
          end
        end
        StLoad: begin
          if (din_hs) begin
            if (idx_q == Last) state_q <= StDone;
            else               idx_q   <= idx_p1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.busy       = (state_q != StIdle) && (state_q != StDone);
    bus.done       = (state_q == StDone);
    bus.RA1        = '0;
    bus.RA2        = '0;
    bus.WE3        = 1'b0;
    bus.WA3        = '0;
    bus.WD3        = '0;
    bus.dout_valid = 1'b0;
    bus.dout_data  = '0;
    bus.dout_idx   = '0;
    bus.din_ready  = 1'b0;
    case (state_q)
      StDumpRead: begin
        bus.RA1 = idx_q;
        // Second port clamps at the last register so an odd count never reads past it.
        bus.RA2 = (idx_p1_wide > 6'(LAST_REG)) ? Last : idx_p1_wide[REG_ADDR_W-1:0];
      end
      StDumpOut0: begin
        bus.dout_valid = 1'b1;
        bus.dout_data  = buf0_q;
        bus.dout_idx   = idx_q;
      end
      StDumpOut1: begin
        bus.dout_valid = 1'b1;
        bus.dout_data  = buf1_q;
        bus.dout_idx   = idx_p1;
      end
      StLoad: begin
        bus.din_ready = 1'b1;
        // x0 is hardwired in the register file, so never address it for writes.
        bus.WE3       = bus.din_valid && (idx_q != '0);
        bus.WA3       = idx_q;
        bus.WD3       = bus.din_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_loader.sv
// Directed bench for reg_dump_loader with a behavioural register file on each instance.
module tb_reg_dump_loader;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_dump_loader_if ifc ();
  reg_dump_loader_if ifc2 ();

  reg_dump_loader #(.FIRST_REG(1), .LAST_REG(31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  reg_dump_loader #(.FIRST_REG(9), .LAST_REG(9)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc2.master)
  );

  logic [31:0] rf  [32];
  logic [31:0] rf2 [32];

  assign ifc.RD1  = rf[ifc.RA1];
  assign ifc.RD2  = rf[ifc.RA2];
  assign ifc2.RD1 = rf2[ifc2.RA1];
  assign ifc2.RD2 = rf2[ifc2.RA2];

  always @(posedge clk) begin
    if (ifc.WE3 && ifc.WA3 != 5'd0) rf[ifc.WA3] <= ifc.WD3;
    if (ifc2.WE3 && ifc2.WA3 != 5'd0) rf2[ifc2.WA3] <= ifc2.WD3;
  end

  typedef struct {
    bit          sd;
    bit          sl;
    bit          busy;
    bit          din_ready;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    bit          valid_next;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Runs one full dump on the main instance; optionally stalls 3 cycles at stall_idx.
  task automatic run_dump(input logic [31:0] base, input int stall_idx, input bit both);
    int expect_idx = 1;
    int stalls     = 0;
    int dones      = 0;
    int first_s    = -1;
    int done_s     = -1;
    ifc.dout_ready = 1'b1;
    ifc.start_dump = 1'b1;
    ifc.start_load = both;
    step();
    ifc.start_dump = 1'b0;
    ifc.start_load = 1'b0;
    for (int s = 0; s < 200 && done_s < 0; s++) begin
      if (both) begin
        chk("both_din_ready", 32'(ifc.din_ready), 32'd0);
        chk("both_we3", 32'(ifc.WE3), 32'd0);
      end
      if (ifc.done) begin
        dones++;
        done_s = s;
      end
      if (ifc.dout_valid) begin
        if (first_s < 0) first_s = s;
        chk("dump_idx", 32'(ifc.dout_idx), 32'(expect_idx));
        chk("dump_data", ifc.dout_data, base + 32'(expect_idx));
        if (expect_idx == stall_idx && stalls < 3) begin
          ifc.dout_ready = 1'b0;
          stalls++;
        end else begin
          ifc.dout_ready = 1'b1;
          expect_idx++;
        end
      end else begin
        ifc.dout_ready = 1'b1;
      end
      step();
    end
    ifc.dout_ready = 1'b1;
    chk("dump_first_valid_cycle", 32'(first_s), 32'd1);
    chk("dump_beats", 32'(expect_idx - 1), 32'd31);
    chk("dump_done_cycle", 32'(done_s), (stall_idx > 0) ? 32'd50 : 32'd47);
    chk("dump_done_count", 32'(dones), 32'd1);
    chk("dump_done_pulse_low", 32'(ifc.done), 32'd0);
    chk("dump_idle_busy", 32'(ifc.busy), 32'd0);
  endtask

  // Loads x1..x31 with base+i; gaps drop din_valid every third cycle.
  task automatic run_load(input logic [31:0] base, input bit gaps);
    int k      = 1;
    int done_s = -1;
    ifc.start_load = 1'b1;
    step();
    ifc.start_load = 1'b0;
    for (int s = 0; s < 200 && done_s < 0; s++) begin
      ifc.din_valid = gaps ? (s % 3 != 1) : 1'b1;
      ifc.din_data  = base + 32'(k);
      #1;
      if (ifc.done) begin
        done_s = s;
        chk("load_done_we3", 32'(ifc.WE3), 32'd0);
      end else begin
        chk("load_din_ready", 32'(ifc.din_ready), 32'd1);
        chk("load_we3", 32'(ifc.WE3), 32'(ifc.din_valid));
        if (ifc.din_valid) begin
          chk("load_wa3", 32'(ifc.WA3), 32'(k));
          chk("load_wd3", ifc.WD3, base + 32'(k));
          k++;
        end
      end
      step();
    end
    ifc.din_valid = 1'b0;
    chk("load_writes", 32'(k - 1), 32'd31);
    chk("load_done_seen", 32'(done_s >= 0), 32'd1);
    chk("load_idle_busy", 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    bit found;
    int beats;
    int dones;
    int first_s;

    for (int i = 0; i < 32; i++) begin
      rf[i]  = 32'd0;
      rf2[i] = 32'd0;
    end
    rf2[9] = 32'h204;

    ifc.start_dump  = 1'b0;
    ifc.start_load  = 1'b0;
    ifc.dout_ready  = 1'b1;
    ifc.din_valid   = 1'b0;
    ifc.din_data    = 32'd0;
    ifc2.start_dump = 1'b0;
    ifc2.start_load = 1'b0;
    ifc2.dout_ready = 1'b1;
    ifc2.din_valid  = 1'b0;
    ifc2.din_data   = 32'd0;

    vecs[0] = '{sd: 0, sl: 0, busy: 0, din_ready: 0, ra1: 5'd0, ra2: 5'd0, valid_next: 0};
    vecs[1] = '{sd: 1, sl: 0, busy: 1, din_ready: 0, ra1: 5'd1, ra2: 5'd2, valid_next: 1};
    vecs[2] = '{sd: 0, sl: 1, busy: 1, din_ready: 1, ra1: 5'd0, ra2: 5'd0, valid_next: 0};
    vecs[3] = '{sd: 1, sl: 1, busy: 1, din_ready: 0, ra1: 5'd1, ra2: 5'd2, valid_next: 1};

    reset = 1'b1;
    repeat (2) step();
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_dout_valid", 32'(ifc.dout_valid), 32'd0);
    chk("rst_din_ready", 32'(ifc.din_ready), 32'd0);
    chk("rst_we3", 32'(ifc.WE3), 32'd0);
    chk("rst_ra1", 32'(ifc.RA1), 32'd0);
    reset = 1'b0;
    step();

    // Start decode from IDLE, aborted by reset after each vector.
    for (int v = 0; v < 4; v++) begin
      ifc.start_dump = vecs[v].sd;
      ifc.start_load = vecs[v].sl;
      step();
      ifc.start_dump = 1'b0;
      ifc.start_load = 1'b0;
      chk($sformatf("vec%0d_busy", v), 32'(ifc.busy), 32'(vecs[v].busy));
      chk($sformatf("vec%0d_din_ready", v), 32'(ifc.din_ready), 32'(vecs[v].din_ready));
      chk($sformatf("vec%0d_ra1", v), 32'(ifc.RA1), 32'(vecs[v].ra1));
      chk($sformatf("vec%0d_ra2", v), 32'(ifc.RA2), 32'(vecs[v].ra2));
      step();
      chk($sformatf("vec%0d_valid", v), 32'(ifc.dout_valid), 32'(vecs[v].valid_next));
      do_reset();
    end

    run_load(32'h100, 1'b0);
    run_dump(32'h100, -1, 1'b0);
    run_dump(32'h100, 5, 1'b0);

    run_load(32'h300, 1'b1);
    chk("rf_x1", rf[1], 32'h301);
    chk("rf_x17", rf[17], 32'h311);
    chk("rf_x31", rf[31], 32'h31f);

    run_dump(32'h300, -1, 1'b1);

    // Reset in the middle of a dump, off the clock edge.
    found = 1'b0;
    ifc.dout_ready = 1'b1;
    ifc.start_dump = 1'b1;
    step();
    ifc.start_dump = 1'b0;
    for (int s = 0; s < 100 && !found; s++) begin
      if (ifc.dout_valid && ifc.dout_idx == 5'd12) found = 1'b1;
      else step();
    end
    chk("mid_found_idx12", 32'(found), 32'd1);
    chk("mid_busy_before", 32'(ifc.busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
    chk("mid_rst_dout_valid", 32'(ifc.dout_valid), 32'd0);
    chk("mid_rst_we3", 32'(ifc.WE3), 32'd0);
    chk("mid_rst_dout_data", ifc.dout_data, 32'd0);
    step();
    reset = 1'b0;
    run_dump(32'h300, -1, 1'b0);

    // Single-register window on the second instance.
    beats   = 0;
    dones   = 0;
    first_s = -1;
    ifc2.start_dump = 1'b1;
    step();
    ifc2.start_dump = 1'b0;
    for (int s = 0; s < 10; s++) begin
      if (ifc2.done) dones++;
      if (ifc2.dout_valid) begin
        if (first_s < 0) first_s = s;
        beats++;
        chk("single_idx", 32'(ifc2.dout_idx), 32'd9);
        chk("single_data", ifc2.dout_data, 32'h204);
      end
      step();
    end
    chk("single_beats", 32'(beats), 32'd1);
    chk("single_first_valid", 32'(first_s), 32'd1);
    chk("single_done", 32'(dones), 32'd1);
    chk("single_idle", 32'(ifc2.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
